// File: rtl/gen_probe_full_logic_pkg.sv
// Shared definitions for the full_logic probe generator.
//   - state_t      : programme FSM encodings
//   - LFSR_TAPS    : feedback mask of the 16-bit Fibonacci LFSR (taps 16,14,13,11)
//   - ST_*         : bit positions inside the 3-bit DUT status vector
//   - lfsr_step()  : one LFSR shift
package gen_probe_full_logic_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RST   = 3'd1,
    S_CFG   = 3'd2,
    S_INIT  = 3'd3,
    S_WRITE = 3'd4,
    S_DRAIN = 3'd5,
    S_DONE  = 3'd6
  } state_t;

  // Taps 16,14,13,11 map to bits 15,13,12,10.
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  // Status vector layout: {error_out, active_out, idle_out}.
  localparam int ST_W      = 3;
  localparam int ST_IDLE   = 0;
  localparam int ST_ACTIVE = 1;
  localparam int ST_ERROR  = 2;

  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return {s[14:0], ^(s & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/gen_probe_full_logic_probe_compare.sv
// probe_compare: registered comparator of two equal-width vectors.
//   clk, rst_n        clock, async active-low reset
//   clr               restart a run: zero counters, first_fail back to FFFF
//   en                compare window; the cycle index advances only here
//   vec_a, vec_b      vectors to compare
//   mismatch_cnt      saturating count of unequal cycles
//   first_fail        cycle index of the first unequal cycle, FFFF if none
module probe_compare #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] vec_a,
  input  logic [W-1:0] vec_b,
  output logic [15:0]  mismatch_cnt,
  output logic [15:0]  first_fail
);

  logic [15:0] cyc_reg;
  logic [15:0] cnt_reg;
  logic [15:0] first_reg;
  logic        seen_reg;
  logic        diff;

  // Case inequality so an X/Z bit on either side reads as a mismatch in
  // simulation; in hardware this is an ordinary inequality.
  always_comb begin
    diff = (vec_a !== vec_b);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc_reg   <= '0;
      cnt_reg   <= '0;
      first_reg <= 16'hFFFF;
      seen_reg  <= 1'b0;
    end else if (clr) begin
      cyc_reg   <= '0;
      cnt_reg   <= '0;
      first_reg <= 16'hFFFF;
      seen_reg  <= 1'b0;
    end else if (en) begin
      if (cyc_reg != 16'hFFFF) cyc_reg <= cyc_reg + 16'd1;
      if (diff) begin
        if (cnt_reg != 16'hFFFF) cnt_reg <= cnt_reg + 16'd1;
        if (!seen_reg) begin
          first_reg <= cyc_reg;
          seen_reg  <= 1'b1;
        end
      end
    end
  end

  assign mismatch_cnt = cnt_reg;
  assign first_fail   = first_reg;

endmodule

// File: rtl/gen_probe_full_logic.sv
// gen_probe_full_logic: stimulus generator and cross-checker for two
// full_logic copies (behavioural and synthesised) fed from one stream.
// Programme: reset -> thresholds -> init -> write burst -> drain -> done.
//   clk, reset              clock, async active-low reset
//   start, mode, burst_len  launch pulse, data mode (0 incr / 1 LFSR), word count
//   cfg_MFs/VCs/Ds          thresholds, latched at start
//   pause                   DUT almost-full, stalls writes
//   dut_reset, wr_enable, data_in, init, umbral_*, pop   DUT drive (registered)
//   data_*/empty_*/err_*/st_*  outputs of the two DUT copies
//   busy, done, mismatch_cnt, first_fail                  programme status
module gen_probe_full_logic
  import gen_probe_full_logic_pkg::*;
#(
  parameter int          DATA_WIDTH   = 6,
  parameter int          NUM_CH       = 2,
  parameter int          UMBRAL_WIDTH = 4,
  parameter int          RST_CYC      = 4,
  parameter int          DRAIN_MAX    = 16,
  parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic                         mode,
  input  logic [7:0]                   burst_len,
  input  logic [UMBRAL_WIDTH-1:0]      cfg_MFs,
  input  logic [UMBRAL_WIDTH-1:0]      cfg_VCs,
  input  logic [UMBRAL_WIDTH-1:0]      cfg_Ds,
  input  logic                         pause,
  output logic                         dut_reset,
  output logic                         wr_enable,
  output logic [DATA_WIDTH-1:0]        data_in,
  output logic                         init,
  output logic [UMBRAL_WIDTH-1:0]      umbral_MFs,
  output logic [UMBRAL_WIDTH-1:0]      umbral_VCs,
  output logic [UMBRAL_WIDTH-1:0]      umbral_Ds,
  output logic [NUM_CH-1:0]            pop,
  input  logic [NUM_CH*DATA_WIDTH-1:0] data_bhv,
  input  logic [NUM_CH*DATA_WIDTH-1:0] data_syn,
  input  logic [NUM_CH-1:0]            empty_bhv,
  input  logic [NUM_CH-1:0]            empty_syn,
  input  logic [NUM_CH-1:0]            err_bhv,
  input  logic [NUM_CH-1:0]            err_syn,
  input  logic [ST_W-1:0]              st_bhv,
  input  logic [ST_W-1:0]              st_syn,
  output logic                         busy,
  output logic                         done,
  output logic [15:0]                  mismatch_cnt,
  output logic [15:0]                  first_fail
);

  localparam int CMP_W = NUM_CH*DATA_WIDTH + 2*NUM_CH + ST_W;

  state_t                  state_reg, state_next;
  logic [7:0]              rst_cnt_reg, drain_cnt_reg, word_cnt_reg, burst_reg;
  logic                    empty_seen_reg, mode_reg;
  logic [15:0]             lfsr_reg;
  logic [DATA_WIDTH-1:0]   data_in_reg;
  logic                    wr_enable_reg, dut_reset_reg, init_reg, busy_reg, done_reg;
  logic [NUM_CH-1:0]       pop_reg;
  logic [UMBRAL_WIDTH-1:0] umbral_mfs_reg, umbral_vcs_reg, umbral_ds_reg;

  logic                    launch, issue, all_empty;
  logic                    dut_reset_next, init_next, busy_next, done_next;
  logic [NUM_CH-1:0]       pop_next;

  // start is honoured only when no programme is running.
  assign launch    = start && ((state_reg == S_IDLE) || (state_reg == S_DONE));
  assign all_empty = &empty_bhv;

  // ---------------- next-state ----------------
  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      S_IDLE:  if (start) state_next = S_RST;
      S_RST:   if (rst_cnt_reg == 8'(RST_CYC - 1)) state_next = S_CFG;
      S_CFG:   state_next = S_INIT;
      S_INIT:  state_next = (burst_reg == 8'd0) ? S_DRAIN : S_WRITE;
      // word_cnt counts words already put on the bus; once it reaches the
      // burst length the last word has been written.
      S_WRITE: if (word_cnt_reg == burst_reg) state_next = S_DRAIN;
      S_DRAIN: if ((all_empty && empty_seen_reg) ||
                   (drain_cnt_reg == 8'(DRAIN_MAX - 1))) state_next = S_DONE;
      S_DONE:  if (start) state_next = S_RST;
      default: state_next = S_IDLE;
    endcase
  end

  // A word is issued for every cycle spent in WRITE while not paused.
  assign issue = (state_next == S_WRITE) && !pause;

  // ---------------- outputs (decoded from the upcoming state) ----------------
  always_comb begin
    dut_reset_next = state_next inside {S_CFG, S_INIT, S_WRITE, S_DRAIN, S_DONE};
    init_next      = state_next inside {S_INIT, S_WRITE, S_DRAIN};
    busy_next      = state_next inside {S_RST, S_CFG, S_INIT, S_WRITE, S_DRAIN};
    done_next      = (state_next == S_DONE);
    pop_next       = (state_next == S_DRAIN) ? '1 : '0;
  end

  // ---------------- state and datapath registers ----------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg      <= S_IDLE;
      rst_cnt_reg    <= '0;
      drain_cnt_reg  <= '0;
      word_cnt_reg   <= '0;
      burst_reg      <= '0;
      empty_seen_reg <= 1'b0;
      mode_reg       <= 1'b0;
      lfsr_reg       <= LFSR_SEED;
      data_in_reg    <= '0;
      wr_enable_reg  <= 1'b0;
      dut_reset_reg  <= 1'b0;
      init_reg       <= 1'b0;
      busy_reg       <= 1'b0;
      done_reg       <= 1'b0;
      pop_reg        <= '0;
      umbral_mfs_reg <= '0;
      umbral_vcs_reg <= '0;
      umbral_ds_reg  <= '0;
    end else begin
      state_reg      <= state_next;
      rst_cnt_reg    <= (state_reg == S_RST)   ? rst_cnt_reg + 8'd1   : 8'd0;
      drain_cnt_reg  <= (state_reg == S_DRAIN) ? drain_cnt_reg + 8'd1 : 8'd0;
      empty_seen_reg <= (state_reg == S_DRAIN) && all_empty;
      if (launch) begin
        mode_reg       <= mode;
        burst_reg      <= burst_len;
        umbral_mfs_reg <= cfg_MFs;
        umbral_vcs_reg <= cfg_VCs;
        umbral_ds_reg  <= cfg_Ds;
        lfsr_reg       <= LFSR_SEED;
        word_cnt_reg   <= '0;
      end else if (issue) begin
        data_in_reg  <= mode_reg ? DATA_WIDTH'(lfsr_reg) : DATA_WIDTH'(word_cnt_reg);
        word_cnt_reg <= word_cnt_reg + 8'd1;
        if (mode_reg) lfsr_reg <= lfsr_step(lfsr_reg);
      end
      wr_enable_reg <= issue;
      dut_reset_reg <= dut_reset_next;
      init_reg      <= init_next;
      busy_reg      <= busy_next;
      done_reg      <= done_next;
      pop_reg       <= pop_next;
    end
  end

  // ---------------- cross-checker ----------------
  logic [ST_W-1:0]  st_bhv_ord, st_syn_ord;
  logic [CMP_W-1:0] vec_bhv, vec_syn;

  assign st_bhv_ord = {st_bhv[ST_ERROR], st_bhv[ST_ACTIVE], st_bhv[ST_IDLE]};
  assign st_syn_ord = {st_syn[ST_ERROR], st_syn[ST_ACTIVE], st_syn[ST_IDLE]};
  assign vec_bhv    = {data_bhv, empty_bhv, err_bhv, st_bhv_ord};
  assign vec_syn    = {data_syn, empty_syn, err_syn, st_syn_ord};

  probe_compare #(.W(CMP_W)) u_cmp (
    .clk          (clk),
    .rst_n        (reset),
    .clr          (launch),
    .en           (state_reg inside {S_CFG, S_INIT, S_WRITE, S_DRAIN}),
    .vec_a        (vec_bhv),
    .vec_b        (vec_syn),
    .mismatch_cnt (mismatch_cnt),
    .first_fail   (first_fail)
  );

  assign dut_reset  = dut_reset_reg;
  assign wr_enable  = wr_enable_reg;
  assign data_in    = data_in_reg;
  assign init       = init_reg;
  assign pop        = pop_reg;
  assign busy       = busy_reg;
  assign done       = done_reg;
  assign umbral_MFs = umbral_mfs_reg;
  assign umbral_VCs = umbral_vcs_reg;
  assign umbral_Ds  = umbral_ds_reg;

endmodule

// File: tb/tb_gen_probe_full_logic.sv
// Directed bench for gen_probe_full_logic. The two "DUT copies" are modelled
// as identical functions of the generator outputs; data_syn can have channel 1
// bit 0 flipped for exactly one checker cycle.
module tb_gen_probe_full_logic;

  logic        clk = 1'b0;
  logic        reset, start, mode, pause;
  logic [7:0]  burst_len;
  logic [3:0]  cfg_MFs, cfg_VCs, cfg_Ds;
  logic        dut_reset, wr_enable, init, busy, done;
  logic [5:0]  data_in;
  logic [3:0]  umbral_MFs, umbral_VCs, umbral_Ds;
  logic [1:0]  pop;
  logic [11:0] data_bhv, data_syn;
  logic [1:0]  empty_bhv, empty_syn, err_bhv, err_syn;
  logic [2:0]  st_bhv, st_syn;
  logic [15:0] mismatch_cnt, first_fail;

  int errors = 0;
  int checks = 0;

  // DUT-copy models
  logic [1:0] tb_empty = 2'b11;
  logic       flip = 1'b0;
  logic       inject = 1'b0;
  assign data_bhv  = {data_in, data_in};
  assign data_syn  = data_bhv ^ (flip ? 12'h040 : 12'h000);
  assign empty_bhv = tb_empty;
  assign empty_syn = tb_empty;
  assign err_bhv   = 2'b00;
  assign err_syn   = 2'b00;
  assign st_bhv    = {1'b0, busy, ~busy};
  assign st_syn    = {1'b0, busy, ~busy};

  gen_probe_full_logic dut (
    .clk(clk), .reset(reset), .start(start), .mode(mode), .burst_len(burst_len),
    .cfg_MFs(cfg_MFs), .cfg_VCs(cfg_VCs), .cfg_Ds(cfg_Ds), .pause(pause),
    .dut_reset(dut_reset), .wr_enable(wr_enable), .data_in(data_in), .init(init),
    .umbral_MFs(umbral_MFs), .umbral_VCs(umbral_VCs), .umbral_Ds(umbral_Ds), .pop(pop),
    .data_bhv(data_bhv), .data_syn(data_syn), .empty_bhv(empty_bhv), .empty_syn(empty_syn),
    .err_bhv(err_bhv), .err_syn(err_syn), .st_bhv(st_bhv), .st_syn(st_syn),
    .busy(busy), .done(done), .mismatch_cnt(mismatch_cnt), .first_fail(first_fail)
  );

  always #5 clk = ~clk;

  // Monitor: records accepted words and counts phase cycles.
  logic [5:0] wr_q[$];
  int pop_cycles = 0;
  int rst_cycles = 0;
  int tb_cyc = 0;
  always @(negedge clk) begin
    if (wr_enable) wr_q.push_back(data_in);
    if (pop == 2'b11) pop_cycles++;
    if (busy && !dut_reset) rst_cycles++;
    if (busy && dut_reset) begin
      flip = inject && (tb_cyc == 20);
      tb_cyc++;
    end else begin
      flip = 1'b0;
      tb_cyc = 0;
    end
  end

  function automatic logic [15:0] ref_step(input logic [15:0] s);
    logic fb;
    fb = s[15] ^ s[13] ^ s[12] ^ s[10];
    return {s[14:0], fb};
  endfunction

  task automatic do_start(input logic m, input logic [7:0] n);
    @(negedge clk);
    mode = m; burst_len = n; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(output logic ok);
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (done) begin ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; start = 0; mode = 0; pause = 0; burst_len = 0;
    cfg_MFs = 4'd5; cfg_VCs = 4'd4; cfg_Ds = 4'd2;
    #2 reset = 1'b0;
    #1;
    checks++;
    if ({dut_reset, wr_enable, init, busy, done, pop} !== 7'd0) begin
      errors++; $display("FAIL reset_ctrl got=%b want=0000000", {dut_reset, wr_enable, init, busy, done, pop});
    end
    checks++;
    if ({data_in, umbral_MFs, umbral_VCs, umbral_Ds} !== 18'd0) begin
      errors++; $display("FAIL reset_data got=%h want=0", {data_in, umbral_MFs, umbral_VCs, umbral_Ds});
    end
    checks++;
    if (mismatch_cnt !== 16'd0 || first_fail !== 16'hFFFF) begin
      errors++; $display("FAIL reset_cmp cnt=%h ff=%h want 0000/FFFF", mismatch_cnt, first_fail);
    end
    repeat (3) @(negedge clk);
    reset = 1'b1;
    $display("reset: idle outputs checked");
  endtask

  task automatic test_incr;
    int base_w, base_p, base_r;
    logic ok;
    base_w = wr_q.size(); base_p = pop_cycles; base_r = rst_cycles;
    do_start(1'b0, 8'd39);
    @(negedge clk);
    checks++;
    if ({umbral_MFs, umbral_VCs, umbral_Ds} !== {4'd5, 4'd4, 4'd2}) begin
      errors++; $display("FAIL incr_umbral got=%h want=542", {umbral_MFs, umbral_VCs, umbral_Ds});
    end
    wait_done(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL incr_done timeout got=0 want=1"); end
    checks++;
    if (rst_cycles - base_r != 4) begin
      errors++; $display("FAIL incr_rst_cycles got=%0d want=4", rst_cycles - base_r);
    end
    checks++;
    if (wr_q.size() - base_w != 39) begin
      errors++; $display("FAIL incr_words got=%0d want=39", wr_q.size() - base_w);
    end else begin
      for (int k = 0; k < 39; k++) begin
        checks++;
        if (wr_q[base_w + k] !== 6'(k)) begin
          errors++; $display("FAIL incr_data[%0d] got=%0d want=%0d", k, wr_q[base_w + k], k);
        end
      end
    end
    checks++;
    if (pop_cycles - base_p != 2) begin
      errors++; $display("FAIL incr_drain_cycles got=%0d want=2", pop_cycles - base_p);
    end
    checks++;
    if (mismatch_cnt !== 16'd0 || first_fail !== 16'hFFFF) begin
      errors++; $display("FAIL incr_cmp cnt=%h ff=%h want 0000/FFFF", mismatch_cnt, first_fail);
    end
    checks++;
    if ({busy, init, pop, dut_reset} !== 5'b00001) begin
      errors++; $display("FAIL incr_done_outs got=%b want=00001", {busy, init, pop, dut_reset});
    end
    $display("incr: %0d words, cnt=%0d ff=%h", wr_q.size() - base_w, mismatch_cnt, first_fail);
  endtask

  task automatic test_lfsr;
    int base_w;
    logic ok;
    logic [15:0] l;
    base_w = wr_q.size();
    do_start(1'b1, 8'd8);
    wait_done(ok);
    checks++;
    if (!ok || wr_q.size() - base_w != 8) begin
      errors++; $display("FAIL lfsr_words got=%0d want=8 done=%b", wr_q.size() - base_w, ok);
    end else begin
      checks++;
      if (wr_q[base_w] !== 6'h21 || wr_q[base_w + 1] !== 6'h03) begin
        errors++; $display("FAIL lfsr_first got=%h,%h want=21,03", wr_q[base_w], wr_q[base_w + 1]);
      end
      l = 16'hACE1;
      for (int k = 0; k < 8; k++) begin
        checks++;
        if (wr_q[base_w + k] !== l[5:0]) begin
          errors++; $display("FAIL lfsr_data[%0d] got=%h want=%h", k, wr_q[base_w + k], l[5:0]);
        end
        l = ref_step(l);
      end
    end
    $display("lfsr: %0d words", wr_q.size() - base_w);
  endtask

  task automatic test_pause;
    int base_w;
    logic ok, hit;
    base_w = wr_q.size();
    do_start(1'b0, 8'd39);
    hit = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (wr_enable && data_in == 6'd10) begin hit = 1'b1; break; end
    end
    checks++;
    if (!hit) begin errors++; $display("FAIL pause_reach word10 got=0 want=1"); end
    pause = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++;
      if (wr_enable !== 1'b0 || data_in !== 6'd10) begin
        errors++; $display("FAIL pause_hold[%0d] wr=%b data=%0d want wr=0 data=10", c, wr_enable, data_in);
      end
    end
    pause = 1'b0;
    wait_done(ok);
    checks++;
    if (!ok || wr_q.size() - base_w != 39) begin
      errors++; $display("FAIL pause_words got=%0d want=39 done=%b", wr_q.size() - base_w, ok);
    end else begin
      for (int k = 0; k < 39; k++) begin
        checks++;
        if (wr_q[base_w + k] !== 6'(k)) begin
          errors++; $display("FAIL pause_data[%0d] got=%0d want=%0d", k, wr_q[base_w + k], k);
        end
      end
    end
    $display("pause: %0d words accepted", wr_q.size() - base_w);
  endtask

  task automatic test_mismatch;
    logic ok;
    inject = 1'b1;
    do_start(1'b0, 8'd39);
    wait_done(ok);
    inject = 1'b0;
    checks++;
    if (!ok) begin errors++; $display("FAIL mm_done timeout got=0 want=1"); end
    checks++;
    if (mismatch_cnt !== 16'd1) begin
      errors++; $display("FAIL mm_count got=%0d want=1", mismatch_cnt);
    end
    checks++;
    if (first_fail !== 16'd20) begin
      errors++; $display("FAIL mm_first got=%0d want=20", first_fail);
    end
    $display("mismatch: cnt=%0d first=%0d", mismatch_cnt, first_fail);
  endtask

  task automatic test_reset_midrun;
    int base_w;
    logic ok, hit;
    do_start(1'b0, 8'd39);
    hit = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (wr_enable && data_in == 6'd15) begin hit = 1'b1; break; end
    end
    checks++;
    if (!hit) begin errors++; $display("FAIL rst_reach word15 got=0 want=1"); end
    #2 reset = 1'b0;
    #1;
    checks++;
    if ({dut_reset, wr_enable, init, busy, done, pop, data_in} !== 13'd0) begin
      errors++; $display("FAIL rst_async_ctrl got=%b want=0", {dut_reset, wr_enable, init, busy, done, pop, data_in});
    end
    checks++;
    if (mismatch_cnt !== 16'd0 || first_fail !== 16'hFFFF || umbral_MFs !== 4'd0) begin
      errors++; $display("FAIL rst_async_cmp cnt=%h ff=%h mfs=%h want 0000/FFFF/0", mismatch_cnt, first_fail, umbral_MFs);
    end
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || dut_reset !== 1'b0) begin
      errors++; $display("FAIL rst_idle busy=%b dut_reset=%b want 0/0", busy, dut_reset);
    end
    base_w = wr_q.size();
    do_start(1'b0, 8'd39);
    wait_done(ok);
    checks++;
    if (!ok || wr_q.size() - base_w != 39) begin
      errors++; $display("FAIL rst_rerun_words got=%0d want=39 done=%b", wr_q.size() - base_w, ok);
    end else begin
      checks++;
      if (wr_q[base_w] !== 6'd0 || wr_q[base_w + 38] !== 6'd38) begin
        errors++; $display("FAIL rst_rerun_data got=%0d..%0d want=0..38", wr_q[base_w], wr_q[base_w + 38]);
      end
    end
    $display("reset_midrun: rerun %0d words", wr_q.size() - base_w);
  endtask

  task automatic test_burst_zero;
    int base_w, base_p;
    logic ok;
    tb_empty = 2'b00;
    base_w = wr_q.size(); base_p = pop_cycles;
    do_start(1'b0, 8'd0);
    wait_done(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL zero_done timeout got=0 want=1"); end
    checks++;
    if (wr_q.size() != base_w) begin
      errors++; $display("FAIL zero_words got=%0d want=0", wr_q.size() - base_w);
    end
    checks++;
    if (pop_cycles - base_p != 16) begin
      errors++; $display("FAIL zero_drain_cycles got=%0d want=16", pop_cycles - base_p);
    end
    tb_empty = 2'b11;
    $display("burst_zero: drain cycles=%0d", pop_cycles - base_p);
  endtask

  initial begin
    test_reset;
    test_incr;
    test_lfsr;
    test_pause;
    test_mismatch;
    test_reset_midrun;
    test_burst_zero;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
